// File: rtl/toggle_window_monitor.sv
// toggle_window_monitor
//
// Watches the 1-bit toggle stream from the counter stage over back-to-back
// windows of WINDOW cycles. For each window it counts rising edges and
// "stuck" cycles (input equal to its previous value). Both counts saturate.
// Each completed window is offered through a one-entry valid/ready slot.
// If a window closes while the slot is still occupied, the new result is
// dropped and the sticky overrun flag is set.
//
// State table:
//   IDLE  | not measuring; window counter and accumulators held at zero
//   COUNT | measuring a window; the close cycle is win_cnt == WINDOW-1
//
// Ports:
//   clk            rising-edge clock for all state
//   reset_n        asynchronous active-low reset (synchronous release upstream)
//   counter_output toggle stream, synchronous to clk
//   enable         1 = measure windows back-to-back, 0 = idle / abort
//   result_ready   consumer accepts the result when high with result_valid
//   result_valid   result_count/result_errors hold a window result
//   result_count   rising edges in the reported window (saturating)
//   result_errors  stuck cycles in the reported window (saturating)
//   overrun        sticky: a completed window was dropped

module toggle_window_monitor #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8,
    parameter int ERR_W  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             counter_output,
    input  logic             enable,
    input  logic             result_ready,
    output logic             result_valid,
    output logic [CNT_W-1:0] result_count,
    output logic [ERR_W-1:0] result_errors,
    output logic             overrun
);

    localparam int WIN_W = ($clog2(WINDOW) > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t           state;
    logic             prev_in;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_acc;
    logic [ERR_W-1:0] err_acc;

    logic             rise;
    logic             stuck;
    logic             win_close;
    logic             slot_free;
    logic [CNT_W-1:0] edge_next;
    logic [ERR_W-1:0] err_next;

    // Saturated running sums including this cycle's event; at the close
    // cycle these are the final window results.
    always_comb begin
        rise      = 1'b0;
        stuck     = 1'b0;
        win_close = 1'b0;
        slot_free = 1'b0;
        edge_next = edge_acc;
        err_next  = err_acc;

        rise      = counter_output & ~prev_in;
        stuck     = (counter_output == prev_in);
        win_close = (state == COUNT) && (win_cnt == WIN_LAST);
        slot_free = ~result_valid | result_ready;

        if (rise && (edge_acc != '1)) begin
            edge_next = edge_acc + CNT_W'(1);
        end
        if (stuck && (err_acc != '1)) begin
            err_next = err_acc + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            prev_in       <= 1'b0;
            win_cnt       <= '0;
            edge_acc      <= '0;
            err_acc       <= '0;
            result_valid  <= 1'b0;
            result_count  <= '0;
            result_errors <= '0;
            overrun       <= 1'b0;
        end else begin
            prev_in <= counter_output;

            case (state)
                IDLE: begin
                    win_cnt  <= '0;
                    edge_acc <= '0;
                    err_acc  <= '0;
                    if (enable) begin
                        state <= COUNT;
                    end
                end

                COUNT: begin
                    if (win_close) begin
                        // Close happens regardless of enable; enable only
                        // decides whether the next window starts at once.
                        win_cnt  <= '0;
                        edge_acc <= '0;
                        err_acc  <= '0;
                        state    <= enable ? COUNT : IDLE;
                    end else if (!enable) begin
                        // Abort: partial window is discarded.
                        win_cnt  <= '0;
                        edge_acc <= '0;
                        err_acc  <= '0;
                        state    <= IDLE;
                    end else begin
                        win_cnt  <= win_cnt + WIN_W'(1);
                        edge_acc <= edge_next;
                        err_acc  <= err_next;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Output slot. A close into a free slot (including one being
            // accepted this edge) reloads and keeps valid high.
            if (win_close && slot_free) begin
                result_count  <= edge_next;
                result_errors <= err_next;
                result_valid  <= 1'b1;
            end else if (win_close) begin
                overrun <= 1'b1;
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_toggle_window_monitor.sv
module tb_toggle_window_monitor;

    localparam int WINDOW = 16;
    localparam int CNT_W  = 8;
    localparam int ERR_W  = 4;

    logic             clk;
    logic             reset_n;
    logic             counter_output;
    logic             enable;
    logic             result_ready;
    logic             result_valid;
    logic [CNT_W-1:0] result_count;
    logic [ERR_W-1:0] result_errors;
    logic             overrun;

    toggle_window_monitor #(
        .WINDOW(WINDOW),
        .CNT_W (CNT_W),
        .ERR_W (ERR_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .counter_output(counter_output),
        .enable        (enable),
        .result_ready  (result_ready),
        .result_valid  (result_valid),
        .result_count  (result_count),
        .result_errors (result_errors),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [ERR_W-1:0] err;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic tog      = 1'b0;
    int   n;
    logic seen_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock. A result offered with ready high is consumed on this edge,
    // so it is popped from the scoreboard and compared before the edge.
    task automatic step();
        res_t e;
        if (reset_n && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_count", 32'(result_count), 32'(e.cnt));
                check("sb_errors", 32'(result_errors), 32'(e.err));
            end
        end
        @(posedge clk);
        #1;
        if (tog) counter_output = ~counter_output;
    endtask

    // Counts edges from now until result_valid is seen; bounded.
    task automatic wait_valid(output int edges);
        edges = 0;
        do begin
            step();
            edges++;
        end while (!result_valid && edges < 40);
    endtask

    task automatic push(input int c, input int e);
        res_t r;
        r.cnt = CNT_W'(c);
        r.err = ERR_W'(e);
        exp_q.push_back(r);
    endtask

    initial begin
        reset_n        = 1'b0;
        counter_output = 1'b0;
        enable         = 1'b0;
        result_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_count", 32'(result_count), 32'd0);
        check("rst_errors", 32'(result_errors), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        step();

        // Nominal toggling stream, back-to-back windows.
        tog = 1'b1;
        result_ready = 1'b1;
        enable = 1'b1;
        push(8, 0); push(8, 0); push(8, 0);
        wait_valid(n);
        check("first_latency", 32'(n), 32'd17);
        wait_valid(n);
        check("period_2", 32'(n), 32'd16);
        wait_valid(n);
        check("period_3", 32'(n), 32'd16);
        step();
        enable = 1'b0;
        repeat (20) step();
        check("nominal_drained", 32'(exp_q.size()), 32'd0);
        check("nominal_no_overrun", 32'(overrun), 32'd0);

        // Input held low: every cycle stuck, error count saturates.
        tog = 1'b0;
        counter_output = 1'b0;
        repeat (2) step();
        enable = 1'b1;
        push(0, 15);
        wait_valid(n);
        check("stuck_latency", 32'(n), 32'd17);
        enable = 1'b0;
        step();
        repeat (20) step();
        check("stuck_drained", 32'(exp_q.size()), 32'd0);

        // Consumer stalls: second close overruns, held result unchanged.
        tog = 1'b1;
        result_ready = 1'b0;
        enable = 1'b1;
        push(8, 0);
        wait_valid(n);
        check("stall_latency", 32'(n), 32'd17);
        repeat (15) step();
        check("stall_no_overrun_yet", 32'(overrun), 32'd0);
        check("stall_count_held", 32'(result_count), 32'd8);
        step();
        check("stall_overrun", 32'(overrun), 32'd1);
        check("stall_valid_held", 32'(result_valid), 32'd1);
        check("stall_count_after", 32'(result_count), 32'd8);
        check("stall_errors_after", 32'(result_errors), 32'd0);
        result_ready = 1'b1;
        enable = 1'b0;
        step();
        check("stall_valid_drop", 32'(result_valid), 32'd0);
        check("stall_overrun_sticky", 32'(overrun), 32'd1);
        repeat (20) step();

        // Reset between edges while a result is held and overrun is set.
        result_ready = 1'b0;
        enable = 1'b1;
        wait_valid(n);
        repeat (5) step();
        check("pre_rst_valid", 32'(result_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(result_valid), 32'd0);
        check("async_rst_count", 32'(result_count), 32'd0);
        check("async_rst_errors", 32'(result_errors), 32'd0);
        check("async_rst_overrun", 32'(overrun), 32'd0);
        result_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        push(8, 0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            counter_output = ~counter_output;
            n++;
        end while (!result_valid && n < 40);
        check("post_rst_latency", 32'(n), 32'd17);
        enable = 1'b0;
        step();
        repeat (20) step();
        check("post_rst_drained", 32'(exp_q.size()), 32'd0);

        // Ready rises exactly on a close while the old result is valid.
        result_ready = 1'b0;
        enable = 1'b1;
        push(8, 0);
        wait_valid(n);
        repeat (15) step();
        check("close_ready_pre_valid", 32'(result_valid), 32'd1);
        result_ready = 1'b1;
        push(8, 0);
        step();
        check("close_ready_valid", 32'(result_valid), 32'd1);
        check("close_ready_overrun", 32'(overrun), 32'd0);
        check("close_ready_count", 32'(result_count), 32'd8);
        enable = 1'b0;
        step();
        check("close_ready_drop", 32'(result_valid), 32'd0);
        repeat (20) step();
        check("close_ready_drained", 32'(exp_q.size()), 32'd0);

        // Abort on the 5th COUNT cycle, then a clean window.
        enable = 1'b1;
        step();
        repeat (4) step();
        enable = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (result_valid) seen_valid = 1'b1;
        end
        check("abort_no_result", 32'(seen_valid), 32'd0);
        enable = 1'b1;
        push(8, 0);
        wait_valid(n);
        check("reenable_latency", 32'(n), 32'd17);
        enable = 1'b0;
        step();
        repeat (5) step();
        check("final_drained", 32'(exp_q.size()), 32'd0);
        check("final_overrun", 32'(overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
